dma_ch_arb: RTL and testbench

DMA_CH_ARB -- requirements
Module: dma_ch_arb

---
 rtl/dma_utils_pkg.sv | 15 +
 rtl/dma_rr_pick.sv | 36 +++
 rtl/dma_ch_arb.sv | 122 ++++++++++++
 tb/tb_dma_ch_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_utils_pkg.sv
// Shared types and defaults for the DMA channel arbiter.
// Holds the arbiter state encoding and the default channel count.
package dma_utils_pkg;

    localparam int DMA_NUM_CH = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        BUSY,
        DONE,
        DRAIN
    } dma_arb_st_t;

endpackage

// File: rtl/dma_rr_pick.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping at N.
// Latency: combinational.
// Backpressure: none; vld is low when no request is present.
module dma_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 vld,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int            j;
    logic [IW-1:0] cand;

    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        j    = 0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            cand = IW'(j);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dma_ch_arb.sv
// Shares one dma_fsm/streamer among NUM_CH channel CSR sets, round-robin; DMA_ARB_WDOG_EN adds a BUSY watchdog.
// Latency: go edge -> GRANT in 2 cycles, fsm_go_o one cycle later; grant-to-grant at least 5 cycles.
// Backpressure: the owner holds the datapath until fsm_done_i; other go edges stay pending meanwhile.
module dma_ch_arb
    import dma_utils_pkg::*;
#(
    parameter int NUM_CH      = DMA_NUM_CH,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_go_i,
    input  logic [NUM_CH-1:0]         ch_abort_i,
    input  logic                      fsm_done_i,
    input  logic                      fsm_error_i,
    output logic                      fsm_go_o,
    output logic                      fsm_abort_o,
    output logic [$clog2(NUM_CH)-1:0] sel_ch_o,
    output logic [NUM_CH-1:0]         ch_busy_o,
    output logic [NUM_CH-1:0]         ch_done_o,
    output logic [NUM_CH-1:0]         ch_err_o
);

    localparam int                IW  = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    dma_arb_st_t       state, state_n;
    logic [NUM_CH-1:0] go_q, pending, go_rise, sel_oh, own_mask, grant_clr, abort_clr;
    logic [IW-1:0]     sel_q, rr_ptr, pick_idx;
    logic              pick_vld, grant_en, err_q, abort_q, wdog_hit;

    dma_rr_pick #(.N(NUM_CH)) u_pick (
        .req (pending),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign grant_en  = (state == IDLE) && pick_vld;
    assign go_rise   = ch_go_i & ~go_q;
    assign sel_oh    = ONE << sel_q;
    assign own_mask  = (state == IDLE) ? '0 : sel_oh;
    assign grant_clr = grant_en ? (ONE << pick_idx) : '0;
    // Aborting the owner is routed to dma_fsm instead of touching its pending bit.
    assign abort_clr = ch_abort_i & ~own_mask;

`ifdef DMA_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            wdog_cnt <= '0;
        end else if (!wdog_hit) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // Saturates, so the forced abort holds until dma_fsm reports done.
    assign wdog_hit = (state == BUSY) && (wdog_cnt == WW'(WDOG_CYCLES));
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_vld) state_n = GRANT;
            GRANT:   state_n = BUSY;
            BUSY:    if (fsm_done_i) state_n = DONE;
            DONE:    state_n = DRAIN;
            DRAIN:   if (!fsm_done_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            // Load the live level so go lines already high never look like an edge.
            go_q    <= ch_go_i;
            pending <= '0;
            rr_ptr  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            go_q    <= ch_go_i;
            pending <= (pending & ~(grant_clr | abort_clr)) | go_rise;
            if (grant_en) begin
                sel_q <= pick_idx;
            end
            if (state == BUSY && (fsm_error_i || wdog_hit)) begin
                err_q <= 1'b1;
            end else if (state == DONE) begin
                err_q <= 1'b0;
            end
            // An abort seen only in the GRANT cycle must still reach dma_fsm in BUSY.
            if (state == GRANT) begin
                abort_q <= ch_abort_i[sel_q];
            end else if (state != BUSY) begin
                abort_q <= 1'b0;
            end
            if (state == DONE) begin
                rr_ptr <= (sel_q == IW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
            end
        end
    end

    assign fsm_go_o    = (state == BUSY);
    assign fsm_abort_o = (state == BUSY) && (ch_abort_i[sel_q] || abort_q || wdog_hit);
    assign sel_ch_o    = sel_q;
    assign ch_busy_o   = own_mask;
    assign ch_done_o   = (state == DONE) ? sel_oh : '0;
    assign ch_err_o    = (state == DONE && err_q) ? sel_oh : '0;

endmodule

// File: tb/tb_dma_ch_arb.sv
// Directed bench for dma_ch_arb: arbitration order, done/error pulses, aborts, reset, optional watchdog.
module tb_dma_ch_arb;

    logic       clk;
    logic       rst;
    logic [3:0] ch_go_i;
    logic [3:0] ch_abort_i;
    logic       fsm_done_i;
    logic       fsm_error_i;
    logic       fsm_go_o;
    logic       fsm_abort_o;
    logic [1:0] sel_ch_o;
    logic [3:0] ch_busy_o;
    logic [3:0] ch_done_o;
    logic [3:0] ch_err_o;

    int checks = 0;
    int errors = 0;

    dma_ch_arb #(.NUM_CH(4), .WDOG_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_go_i     (ch_go_i),
        .ch_abort_i  (ch_abort_i),
        .fsm_done_i  (fsm_done_i),
        .fsm_error_i (fsm_error_i),
        .fsm_go_o    (fsm_go_o),
        .fsm_abort_o (fsm_abort_o),
        .sel_ch_o    (sel_ch_o),
        .ch_busy_o   (ch_busy_o),
        .ch_done_o   (ch_done_o),
        .ch_err_o    (ch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse go lines for one cycle so each produces exactly one edge.
    task automatic go_pulse(input logic [3:0] mask);
        ch_go_i = mask;
        tick();
        ch_go_i = 4'b0000;
    endtask

    task automatic wait_grant(input logic [1:0] exp_sel, input string tag);
        bit         found = 0;
        logic [3:0] oh    = 4'b0001 << exp_sel;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (ch_busy_o !== 4'b0000) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_grant_timeout busy=%b exp=%b", tag, ch_busy_o, oh);
        end else begin
            if (sel_ch_o !== exp_sel || ch_busy_o !== oh || fsm_go_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_grant sel=%0d busy=%b go=%b exp sel=%0d busy=%b go=0",
                         tag, sel_ch_o, ch_busy_o, fsm_go_o, exp_sel, oh);
            end
        end
    endtask

    // Entered at a BUSY-cycle negedge; completes the DONE/DRAIN/IDLE handshake.
    task automatic finish_grant(input logic [1:0] exp_sel, input logic exp_err, input string tag);
        logic [3:0] oh = 4'b0001 << exp_sel;
        fsm_done_i = 1'b1;
        tick();
        fsm_error_i = 1'b0;
        checks++;
        if (ch_done_o !== oh || ch_err_o !== (exp_err ? oh : 4'b0000) || fsm_go_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done=%b err=%b go=%b exp done=%b err=%b go=0",
                     tag, ch_done_o, ch_err_o, fsm_go_o, oh, exp_err ? oh : 4'b0000);
        end
        tick();
        checks++;
        if (ch_done_o !== 4'b0000 || ch_err_o !== 4'b0000 || ch_busy_o !== oh || sel_ch_o !== exp_sel) begin
            errors++;
            $display("FAIL %s_drain done=%b err=%b busy=%b sel=%0d exp done=0 err=0 busy=%b sel=%0d",
                     tag, ch_done_o, ch_err_o, ch_busy_o, sel_ch_o, oh, exp_sel);
        end
        fsm_done_i = 1'b0;
        tick();
        checks++;
        if (ch_busy_o !== 4'b0000) begin
            errors++;
            $display("FAIL %s_idle busy=%b exp=0000", tag, ch_busy_o);
        end
    endtask

    task automatic do_grant(input logic [1:0] exp_sel, input int nbusy, input int err_cyc,
                            input logic exp_err, input string tag);
        int go_cnt = 0;
        wait_grant(exp_sel, tag);
        for (int k = 1; k <= nbusy; k++) begin
            tick();
            if (fsm_go_o === 1'b1) go_cnt++;
            fsm_error_i = (k == err_cyc);
        end
        checks++;
        if (go_cnt != nbusy) begin
            errors++;
            $display("FAIL %s_go_len got=%0d exp=%0d", tag, go_cnt, nbusy);
        end
        finish_grant(exp_sel, exp_err, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_go_i = 4'b0000;
        ch_abort_i = 4'b0000;
        fsm_done_i = 1'b0;
        fsm_error_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({fsm_go_o, fsm_abort_o, sel_ch_o, ch_busy_o, ch_done_o, ch_err_o} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs go=%b abort=%b sel=%0d busy=%b done=%b err=%b exp all 0",
                     fsm_go_o, fsm_abort_o, sel_ch_o, ch_busy_o, ch_done_o, ch_err_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_order();
        go_pulse(4'b1011);
        do_grant(2'd0, 3, 0, 1'b0, "rr0");
        do_grant(2'd1, 3, 0, 1'b0, "rr1");
        do_grant(2'd3, 3, 0, 1'b0, "rr3");
        // Pointer must be back at 0: channel 1 wins over 3.
        go_pulse(4'b1010);
        do_grant(2'd1, 2, 0, 1'b0, "ptr1");
        do_grant(2'd3, 2, 0, 1'b0, "ptr3");
    endtask

    task automatic test_single();
        int go_cnt = 0;
        go_pulse(4'b0000);
        ch_go_i = 4'b0100;
        wait_grant(2'd2, "single");
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (fsm_go_o === 1'b1) go_cnt++;
            if (k == 3) ch_go_i = 4'b0000;
        end
        checks++;
        if (go_cnt != 10) begin
            errors++;
            $display("FAIL single_go_len got=%0d exp=10", go_cnt);
        end
        finish_grant(2'd2, 1'b0, "single");
    endtask

    task automatic test_error();
        go_pulse(4'b0010);
        do_grant(2'd1, 6, 3, 1'b1, "err");
        go_pulse(4'b0010);
        do_grant(2'd1, 4, 0, 1'b0, "err_clr");
    endtask

    task automatic test_abort();
        bit leak = 0;
        go_pulse(4'b1001);
        wait_grant(2'd3, "abort");
        tick();
        ch_abort_i = 4'b0001;
        #1;
        checks++;
        if (fsm_abort_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_nonowner got=%b exp=0", fsm_abort_o);
        end
        tick();
        ch_abort_i = 4'b1000;
        #1;
        checks++;
        if (fsm_abort_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_owner got=%b exp=1", fsm_abort_o);
        end
        tick();
        ch_abort_i = 4'b0000;
        #1;
        checks++;
        if (fsm_abort_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_release got=%b exp=0", fsm_abort_o);
        end
        finish_grant(2'd3, 1'b0, "abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ch_busy_o !== 4'b0000 || ch_done_o !== 4'b0000) leak = 1;
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL abort_ch0_granted leak=%b exp=0", leak);
        end
        // Abort raised only during the GRANT cycle.
        go_pulse(4'b0010);
        wait_grant(2'd1, "abort_grant");
        ch_abort_i = 4'b0010;
        #1;
        checks++;
        if (fsm_abort_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_grant got=%b exp=0", fsm_abort_o);
        end
        tick();
        ch_abort_i = 4'b0000;
        #1;
        checks++;
        if (fsm_abort_o !== 1'b1 || fsm_go_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_carried abort=%b go=%b exp abort=1 go=1", fsm_abort_o, fsm_go_o);
        end
        finish_grant(2'd1, 1'b0, "abort_grant");
    endtask

`ifdef DMA_ARB_WDOG_EN
    task automatic test_wdog();
        bit early = 0;
        go_pulse(4'b0100);
        wait_grant(2'd2, "wdog");
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (fsm_abort_o !== 1'b0) early = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL wdog_early early=%b exp=0", early);
        end
        tick();
        checks++;
        if (fsm_abort_o !== 1'b1) begin
            errors++;
            $display("FAIL wdog_fire got=%b exp=1", fsm_abort_o);
        end
        tick();
        checks++;
        if (fsm_abort_o !== 1'b1) begin
            errors++;
            $display("FAIL wdog_hold got=%b exp=1", fsm_abort_o);
        end
        finish_grant(2'd2, 1'b1, "wdog");
    endtask
`endif

    task automatic test_reset_mid_busy();
        bit regrant = 0;
        ch_go_i = 4'b0001;
        tick();
        wait_grant(2'd0, "rstmid");
        tick();
        checks++;
        if (fsm_go_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy go=%b exp=1", fsm_go_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({fsm_go_o, fsm_abort_o, sel_ch_o, ch_busy_o, ch_done_o, ch_err_o} !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_outputs go=%b abort=%b sel=%0d busy=%b done=%b err=%b exp all 0",
                     fsm_go_o, fsm_abort_o, sel_ch_o, ch_busy_o, ch_done_o, ch_err_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ch_busy_o !== 4'b0000) regrant = 1;
        end
        checks++;
        if (regrant) begin
            errors++;
            $display("FAIL rstmid_stale_grant got=%b exp=0", regrant);
        end
        ch_go_i = 4'b0000;
        tick();
        ch_go_i = 4'b0001;
        tick();
        wait_grant(2'd0, "rstmid_fresh");
        tick();
        finish_grant(2'd0, 1'b0, "rstmid_fresh");
        ch_go_i = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_single();
        test_error();
        test_abort();
`ifdef DMA_ARB_WDOG_EN
        test_wdog();
`endif
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
